// File: rtl/ascii_load_scheduler.sv
// ascii_load_scheduler
//   Feeds "Load Ascii" file downloads from the hps_io ioctl stream into the
//   ACIA receive path at a pace the UK101/OSI monitor and BASIC can keep up
//   with. Bytes are filtered (line-ending normalisation, optional upper-case
//   folding), buffered in a small FIFO, then presented one at a time with an
//   idle gap after each accepted character and a longer gap after CR.
//
// Ports
//   clk_sys        in   system clock
//   reset          in   asynchronous, active-high
//   load_from      in   0 = file download feeds the ACIA, 1 = UART feeds it
//   ioctl_download in   download in progress
//   ioctl_wr       in   one-cycle byte strobe
//   ioctl_dout     in   download byte
//   ioctl_wait     out  backpressure to hps_io (fill >= FIFO_DEPTH-2)
//   rx_data        out  byte to ACIA receive register
//   rx_valid       out  rx_data valid
//   rx_ready       in   ACIA accepts the byte
//   file_active    out  1 while this block owns the ACIA RX path
//   busy           out  FIFO non-empty or sequencer not idle
//   overflow       out  sticky: byte written while FIFO full
module ascii_load_scheduler #(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned GAP_CYCLES    = 48000,
  parameter int unsigned CR_GAP_CYCLES = 4800000,
  parameter bit          UPPERCASE     = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load_from,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_dout,
  output logic       ioctl_wait,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       file_active,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 2);
  localparam logic [22:0]   GAP_LOAD = 23'(GAP_CYCLES - 1);
  localparam logic [22:0]   CR_LOAD  = 23'(CR_GAP_CYCLES - 1);
  localparam logic [7:0]    CR       = 8'h0D;
  localparam logic [7:0]    LF       = 8'h0A;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fill, fill_nxt;
  logic          dl_q, dl_rise, prev_cr;
  logic          flush, wr_en, keep, full, push, pop;
  logic [7:0]    push_byte;

  state_t        state, state_nxt;
  logic [22:0]   cnt, cnt_nxt;
  logic [7:0]    data_nxt;
  logic          valid_nxt;

  // A new download, or the UART taking over the RX path, discards
  // everything queued and returns the sequencer to idle.
  assign dl_rise = ioctl_download & ~dl_q;
  assign flush   = dl_rise | load_from;
  assign wr_en   = ioctl_wr & ~load_from;
  assign full    = (fill == FULL_LVL);
  assign push    = wr_en & keep & ~full & ~flush;
  assign busy    = (fill != '0) | (state != IDLE);

  // Line-ending normalisation: LF directly after CR vanishes, a lone LF
  // becomes CR. Lower-case letters are folded when UPPERCASE is set.
  always_comb begin
    keep      = 1'b1;
    push_byte = ioctl_dout;
    if (ioctl_dout == LF) begin
      keep      = ~prev_cr;
      push_byte = CR;
    end else if (UPPERCASE && ioctl_dout >= 8'h61 && ioctl_dout <= 8'h7A) begin
      push_byte = ioctl_dout - 8'h20;
    end
  end

  assign fill_nxt = flush ? '0 : fill + CW'(push) - CW'(pop);

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      dl_q        <= 1'b0;
      prev_cr     <= 1'b0;
      overflow    <= 1'b0;
      ioctl_wait  <= 1'b0;
      file_active <= 1'b0;
    end else begin
      dl_q        <= ioctl_download;
      fill        <= fill_nxt;
      // Driven from the next fill so the strobe already in flight when
      // hps_io sees the wait still has a free slot.
      ioctl_wait  <= ~load_from & (fill_nxt >= WAIT_LVL);
      file_active <= ~load_from & (ioctl_download | busy);
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        prev_cr <= 1'b0;
        if (dl_rise) overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (wr_en) prev_cr <= (ioctl_dout == CR);
        if (wr_en & keep & full) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rx_data  <= data_nxt;
      rx_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = rx_data;
    valid_nxt = rx_valid;
    pop       = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      valid_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fill != '0) begin
            pop       = 1'b1;
            data_nxt  = mem[rd_ptr];
            valid_nxt = 1'b1;
            state_nxt = PRESENT;
          end
        end
        PRESENT: begin
          if (rx_ready) begin
            valid_nxt = 1'b0;
            cnt_nxt   = (rx_data == CR) ? CR_LOAD : GAP_LOAD;
            state_nxt = GAP;
          end
        end
        GAP: begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
